// File: rtl/ram_rd_streamer_if.sv
`default_nettype none
// ============================================================================
// ram_rd_streamer_if : command, RAM read-port and stream signals of ram_rd_streamer
// Rev 1.0
// ============================================================================
interface ram_rd_streamer_if #(
  parameter int MEM_DEPTH = 64,
  parameter int MEM_WIDTH = 32,
  parameter int LEN_WIDTH = 16
);
  localparam int c_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic                 start_i;
  logic [c_AW-1:0]      base_i;
  logic [LEN_WIDTH-1:0] len_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 rd_en_o;
  logic [c_AW-1:0]      rd_addr_o;
  logic [MEM_WIDTH-1:0] rd_data_i;
  logic [MEM_WIDTH-1:0] m_tdata_o;
  logic                 m_tvalid_o;
  logic                 m_tlast_o;
  logic                 m_tready_i;

  modport master (
    input  start_i, base_i, len_i, rd_data_i, m_tready_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, m_tdata_o, m_tvalid_o, m_tlast_o
  );

  modport slave (
    output start_i, base_i, len_i, rd_data_i, m_tready_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, m_tdata_o, m_tvalid_o, m_tlast_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_rd_streamer.sv
`default_nettype none
// ============================================================================
// ram_rd_streamer : fixed-latency RAM read engine with credit-counted stream FIFO
// Rev 1.0
// ============================================================================
module ram_rd_streamer #(
  parameter int MEM_DEPTH  = 64,
  parameter int MEM_WIDTH  = 32,
  parameter int RD_LATENCY = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  ram_rd_streamer_if.master bus
);
  localparam int c_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_FW = c_PW + 1;
  localparam int c_CW = c_PW + 2;
  localparam logic [c_AW-1:0]      c_LAST_ADDR = c_AW'(MEM_DEPTH - 1);
  localparam logic [c_AW-1:0]      c_ADDR_ONE  = c_AW'(1);
  localparam logic [LEN_WIDTH-1:0] c_LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [c_FW-1:0]      c_PTR_ONE   = c_FW'(1);
  localparam logic [c_FW-1:0]      c_FIFO_FULL = c_FW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]      c_CREDITS   = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q;
  logic [c_AW-1:0]      addr_q;
  logic [LEN_WIDTH-1:0] issue_cnt_q;
  logic [LEN_WIDTH-1:0] out_cnt_q;
  logic                 done_q;
  logic [RD_LATENCY-1:0] pipe_q;
  logic [RD_LATENCY-1:0] pipe_d;
  logic [MEM_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [c_FW-1:0]      wr_ptr_q;
  logic [c_FW-1:0]      rd_ptr_q;
  logic [c_FW-1:0]      fifo_cnt;
  logic [c_CW-1:0]      inflight;
  logic                 rd_issue;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 last_beat;
  logic                 last_pop;
  logic                 cmd_start;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + c_CW'(pipe_q[i]);
    end
  end

  // A read may only issue if a FIFO slot is guaranteed for its return data.
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign rd_issue   = (state_q == S_ISSUE) && ((inflight + c_CW'(fifo_cnt)) < c_CREDITS);
  assign fifo_push  = pipe_q[RD_LATENCY-1];
  assign fifo_pop   = !fifo_empty && bus.m_tready_i;
  assign last_beat  = (out_cnt_q == c_LEN_ONE);
  assign last_pop   = (state_q == S_DRAIN) && fifo_pop && last_beat;
  assign cmd_start  = (state_q == S_IDLE) && bus.start_i;

  generate
    if (RD_LATENCY == 1) begin : g_pipe_single
      assign pipe_d = rd_issue;
    end else begin : g_pipe_shift
      assign pipe_d = {pipe_q[RD_LATENCY-2:0], rd_issue};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              addr_q      <= bus.base_i;
              issue_cnt_q <= bus.len_i;
            end
          end
        end
        S_ISSUE: begin
          if (rd_issue) begin
            addr_q      <= (addr_q == c_LAST_ADDR) ? '0 : addr_q + c_ADDR_ONE;
            issue_cnt_q <= issue_cnt_q - c_LEN_ONE;
            if (issue_cnt_q == c_LEN_ONE) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (cmd_start && (bus.len_i != '0)) begin
        out_cnt_q <= bus.len_i;
      end else if (fifo_pop) begin
        out_cnt_q <= out_cnt_q - c_LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_q[wr_ptr_q[c_PW-1:0]] <= bus.rd_data_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rstn_i && fifo_push && !fifo_pop) begin
      assert (fifo_cnt < c_FIFO_FULL)
        else $error("ram_rd_streamer: output FIFO overflow");
    end
  end
`endif

  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.done_o     = done_q || last_pop;
  assign bus.rd_en_o    = rd_issue;
  assign bus.rd_addr_o  = addr_q;
  assign bus.m_tvalid_o = !fifo_empty;
  assign bus.m_tdata_o  = fifo_empty ? '0 : fifo_q[rd_ptr_q[c_PW-1:0]];
  assign bus.m_tlast_o  = !fifo_empty && last_beat;

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_streamer.sv
`default_nettype none
// ============================================================================
// tb_ram_rd_streamer : directed scoreboard bench for ram_rd_streamer
// Rev 1.0
// ============================================================================
module tb_ram_rd_streamer;
  localparam int c_DEPTH = 64;
  localparam int c_WIDTH = 32;
  localparam int c_LAT   = 5;
  localparam int c_FIFO  = 8;
  localparam int c_LENW  = 16;

  typedef struct {
    logic [c_WIDTH-1:0] data;
    logic               last;
  } beat_t;

  logic clk;
  logic rstn;

  ram_rd_streamer_if #(.MEM_DEPTH(c_DEPTH), .MEM_WIDTH(c_WIDTH), .LEN_WIDTH(c_LENW)) bus ();

  ram_rd_streamer #(
    .MEM_DEPTH (c_DEPTH),
    .MEM_WIDTH (c_WIDTH),
    .RD_LATENCY(c_LAT),
    .FIFO_DEPTH(c_FIFO),
    .LEN_WIDTH (c_LENW)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data for a read appears RD_LATENCY cycles after its enable
  logic [c_WIDTH-1:0] ram [c_DEPTH];
  logic [5:0]         ra  [c_LAT];
  logic               rv  [c_LAT];

  always @(posedge clk) begin
    ra[0] <= bus.rd_addr_o;
    rv[0] <= bus.rd_en_o;
    for (int i = 1; i < c_LAT; i++) begin
      ra[i] <= ra[i-1];
      rv[i] <= rv[i-1];
    end
  end
  assign bus.rd_data_i = rv[c_LAT-1] ? ram[ra[c_LAT-1]] : 32'hDEAD_BEEF;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [5:0]   exp_addr_q [$];
  beat_t        exp_data_q [$];
  int           issued = 0;
  int           popped = 0;
  bit           zl_mode = 1'b0;
  bit           bp_mode = 1'b0;
  bit           hold_prev = 1'b0;
  logic [31:0]  prev_data;
  logic         prev_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Monitor: scoreboard pops on each read issue and each stream handshake
  always @(negedge clk) begin
    beat_t e;
    logic  hs;
    logic  exp_last;
    if (rstn) begin
      hs       = bus.m_tvalid_o && bus.m_tready_i;
      exp_last = 1'b0;
      if (bus.rd_en_o) begin
        issued++;
        if (exp_addr_q.size() == 0) check("rd_en_unexpected", 32'(bus.rd_en_o), 32'd0);
        else check("rd_addr", 32'(bus.rd_addr_o), 32'(exp_addr_q.pop_front()));
      end
      if (hold_prev) begin
        check("hold_valid", 32'(bus.m_tvalid_o), 32'd1);
        check("hold_data", bus.m_tdata_o, prev_data);
        check("hold_last", 32'(bus.m_tlast_o), 32'(prev_last));
      end
      if (hs) begin
        popped++;
        if (exp_data_q.size() == 0) begin
          check("tvalid_unexpected", 32'(bus.m_tvalid_o), 32'd0);
        end else begin
          e = exp_data_q.pop_front();
          exp_last = e.last;
          check("tdata", bus.m_tdata_o, e.data);
          check("tlast", 32'(bus.m_tlast_o), 32'(e.last));
        end
      end
      if (!zl_mode && (bus.done_o || hs))
        check("done", 32'(bus.done_o), 32'(hs && exp_last));
      if (bp_mode)
        check("outstanding", 32'((issued - popped) <= c_FIFO), 32'd1);
      hold_prev = bus.m_tvalid_o && !bus.m_tready_i;
      prev_data = bus.m_tdata_o;
      prev_last = bus.m_tlast_o;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic start_cmd(input int base, input int len);
    int a;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.base_i  = 6'(base);
    bus.len_i   = 16'(len);
    for (int i = 0; i < len; i++) begin
      a = (base + i) % c_DEPTH;
      exp_addr_q.push_back(6'(a));
      exp_data_q.push_back('{data: ram[a], last: (i == len - 1)});
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n = 0;
    while ((bus.busy_o || exp_data_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      if (rand_ready) bus.m_tready_i = 1'($urandom_range(0, 1));
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    check("addr_left", 32'(exp_addr_q.size()), 32'd0);
    bus.m_tready_i = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(bus.busy_o),     32'd0);
    check({tag, "_done"},   32'(bus.done_o),     32'd0);
    check({tag, "_rd_en"},  32'(bus.rd_en_o),    32'd0);
    check({tag, "_addr"},   32'(bus.rd_addr_o),  32'd0);
    check({tag, "_tvalid"}, 32'(bus.m_tvalid_o), 32'd0);
    check({tag, "_tlast"},  32'(bus.m_tlast_o),  32'd0);
    check({tag, "_tdata"},  bus.m_tdata_o,       32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int p0;
    for (int i = 0; i < c_DEPTH; i++) ram[i] = 32'(i);
    rstn           = 1'b0;
    bus.start_i    = 1'b0;
    bus.base_i     = '0;
    bus.len_i      = '0;
    bus.m_tready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // Basic: base=3, len=4, first valid RD_LATENCY+1 cycles after start
    start_cmd(3, 4);
    check("busy_after_start", 32'(bus.busy_o), 32'd1);
    lat = 0;
    while (!bus.m_tvalid_o && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_latency", 32'(lat), 32'(c_LAT + 1));
    for (int k = 0; k < 4; k++) begin
      check("tput_valid", 32'(bus.m_tvalid_o), 32'd1);
      check("tput_data", bus.m_tdata_o, 32'(3 + k));
      @(posedge clk); #1;
    end
    wait_idle(50, 1'b0);

    // Wrap: 62,63,0,1
    start_cmd(62, 4);
    wait_idle(50, 1'b0);

    // Zero length: done one cycle later, no reads
    zl_mode = 1'b1;
    start_cmd(5, 0);
    check("zl_done", 32'(bus.done_o), 32'd1);
    check("zl_busy", 32'(bus.busy_o), 32'd0);
    check("zl_rd_en", 32'(bus.rd_en_o), 32'd0);
    @(posedge clk); #1;
    check("zl_done_clear", 32'(bus.done_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    zl_mode = 1'b0;

    // Start while busy is ignored
    start_cmd(10, 6);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.base_i  = 6'd40;
    bus.len_i   = 16'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_idle(60, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_idle", 32'(bus.busy_o), 32'd0);

    // Backpressure: stall 20 cycles, then random ready
    issued = 0;
    popped = 0;
    bp_mode = 1'b1;
    bus.m_tready_i = 1'b0;
    start_cmd(20, 32);
    repeat (20) @(posedge clk);
    #1;
    check("stall_issued", 32'(issued), 32'(c_FIFO));
    wait_idle(800, 1'b1);
    check("bp_popped", 32'(popped), 32'd32);
    bp_mode = 1'b0;

    // Reset after 3 of 10 words, then a fresh command
    start_cmd(30, 10);
    p0 = popped;
    n  = 0;
    while (popped - p0 < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reset_reach", 32'(n < 100), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    exp_addr_q.delete();
    exp_data_q.delete();
    rstn = 1'b1;
    start_cmd(50, 5);
    wait_idle(60, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("final_tvalid", 32'(bus.m_tvalid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
